// File: rtl/mux_scan.sv
// mux_scan: registered N-channel, W-bit multiplexer with a time-division scan
// mode. In scan mode it steps through every channel and holds each one for a
// programmable dwell. It tags each sample with its channel and raises strobes
// so downstream logic can pick the shared stream apart again.
module mux_scan #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int DWELL_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [DWELL_W-1:0]        dwell,
  input  logic [CHANNELS*WIDTH-1:0] d,
  output logic [WIDTH-1:0]          z0,
  output logic [SEL_W-1:0]          ch,
  output logic                      valid,
  output logic                      first,
  output logic                      wrap
);

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

  logic [WIDTH-1:0]   z0_q, z0_d;
  logic [SEL_W-1:0]   ch_q, ch_d;
  logic               valid_q, valid_d;
  logic               first_q, first_d;
  logic               wrap_q, wrap_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               prevMode_q, prevMode_d;

  // Pointer and count actually used this cycle. Entering scan mode forces the
  // sweep to restart at channel 0, so those cycles read zeros here.
  logic [SEL_W-1:0]   effPtr;
  logic [DWELL_W-1:0] effCnt;

  // Next-state logic: freeze, manual select, or scan step, with strobes cleared by default.
  always_comb begin
    z0_d       = z0_q;
    ch_d       = ch_q;
    valid_d    = 1'b0;
    first_d    = 1'b0;
    wrap_d     = 1'b0;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    prevMode_d = prevMode_q;
    effPtr     = ptr_q;
    effCnt     = cnt_q;

    if (enable) begin
      prevMode_d = mode;
      if (!mode) begin
        ptr_d = '0;
        cnt_d = '0;
        if (32'(sel) < CHANNELS) begin
          z0_d    = d[32'(sel)*WIDTH +: WIDTH];
          ch_d    = sel;
          valid_d = 1'b1;
          first_d = 1'b1;
        end
      end else begin
        if (!prevMode_q) begin
          effPtr = '0;
          effCnt = '0;
        end
        z0_d    = d[32'(effPtr)*WIDTH +: WIDTH];
        ch_d    = effPtr;
        valid_d = 1'b1;
        first_d = (effCnt == '0);
        wrap_d  = (effCnt == '0) && (effPtr == '0);
        // Using >= lets a lowered dwell end the current channel at once.
        if (effCnt >= dwell) begin
          cnt_d = '0;
          ptr_d = (effPtr == LAST_CH) ? '0 : effPtr + 1'b1;
        end else begin
          cnt_d = effCnt + 1'b1;
        end
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      z0_q       <= '0;
      ch_q       <= '0;
      valid_q    <= 1'b0;
      first_q    <= 1'b0;
      wrap_q     <= 1'b0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      prevMode_q <= 1'b0;
    end else begin
      z0_q       <= z0_d;
      ch_q       <= ch_d;
      valid_q    <= valid_d;
      first_q    <= first_d;
      wrap_q     <= wrap_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      prevMode_q <= prevMode_d;
    end
  end

  assign z0    = z0_q;
  assign ch    = ch_q;
  assign valid = valid_q;
  assign first = first_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_mux_scan.sv
// tb_mux_scan: directed-vector bench for mux_scan. It uses a 4-channel
// instance for manual, scan, dwell, freeze and reset behaviour. It uses a
// 3-channel instance for the out-of-range select case.
module tb_mux_scan;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        mode;
  logic [1:0]  sel;
  logic [7:0]  dwell;
  logic [31:0] d;
  logic [23:0] d3;

  logic [7:0]  z0;
  logic [1:0]  ch;
  logic        valid, first, wrap;

  logic [7:0]  z0b;
  logic [1:0]  chb;
  logic        validb, firstb, wrapb;

  int checkCount;
  int errCount;

  logic [7:0] expVal [4];

  mux_scan #(.WIDTH(8), .CHANNELS(4), .SEL_W(2), .DWELL_W(8)) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .sel(sel),
    .dwell(dwell), .d(d), .z0(z0), .ch(ch), .valid(valid),
    .first(first), .wrap(wrap)
  );

  mux_scan #(.WIDTH(8), .CHANNELS(3), .SEL_W(2), .DWELL_W(8)) dut3 (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .sel(sel),
    .dwell(dwell), .d(d3), .z0(z0b), .ch(chb), .valid(validb),
    .first(firstb), .wrap(wrapb)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Count one comparison and report it if observed differs from expected.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Check all five outputs of the 4-channel instance.
  task automatic checkAll(input string tag, input logic [7:0] expZ,
                          input logic [1:0] expCh, input logic expV,
                          input logic expF, input logic expW);
    checkOutput({tag, ".z0"}, 32'(z0), 32'(expZ));
    checkOutput({tag, ".ch"}, 32'(ch), 32'(expCh));
    checkOutput({tag, ".valid"}, 32'(valid), 32'(expV));
    checkOutput({tag, ".first"}, 32'(first), 32'(expF));
    checkOutput({tag, ".wrap"}, 32'(wrap), 32'(expW));
  endtask

  // Drive one cycle of inputs, then sample just after the rising edge.
  task automatic applyStimulus(input logic en, input logic md,
                               input logic [1:0] s, input logic [7:0] dw);
    enable = en;
    mode   = md;
    sel    = s;
    dwell  = dw;
    @(posedge clk);
    #1;
  endtask

  initial begin
    clk        = 1'b0;
    rst        = 1'b1;
    enable     = 1'b0;
    mode       = 1'b0;
    sel        = 2'd0;
    dwell      = 8'd0;
    d          = {8'h44, 8'h33, 8'h22, 8'h11};
    d3         = {8'hCC, 8'hBB, 8'hAA};
    checkCount = 0;
    errCount   = 0;
    expVal     = '{8'h11, 8'h22, 8'h33, 8'h44};

    // Reset values on both instances.
    applyStimulus(1'b0, 1'b0, 2'd0, 8'd0);
    applyStimulus(1'b0, 1'b0, 2'd0, 8'd0);
    checkAll("reset", 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset3.z0", 32'(z0b), 32'h0);
    checkOutput("reset3.valid", 32'(validb), 32'h0);
    rst = 1'b0;

    // Manual select of channel 2.
    applyStimulus(1'b1, 1'b0, 2'd2, 8'd0);
    checkAll("manual2", 8'h33, 2'd2, 1'b1, 1'b1, 1'b0);
    checkOutput("man3.z0", 32'(z0b), 32'hCC);
    checkOutput("man3.ch", 32'(chb), 32'd2);
    checkOutput("man3.valid", 32'(validb), 32'd1);

    // sel = 3: in range for 4 channels, out of range for 3 channels.
    applyStimulus(1'b1, 1'b0, 2'd3, 8'd0);
    checkAll("manual3", 8'h44, 2'd3, 1'b1, 1'b1, 1'b0);
    checkOutput("oor.z0", 32'(z0b), 32'hCC);
    checkOutput("oor.ch", 32'(chb), 32'd2);
    checkOutput("oor.valid", 32'(validb), 32'd0);
    checkOutput("oor.first", 32'(firstb), 32'd0);
    checkOutput("oor.wrap", 32'(wrapb), 32'd0);

    // Scan with dwell 0: one channel per cycle, starting at channel 0.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b1, 2'd0, 8'd0);
      checkAll($sformatf("scan0[%0d]", i), expVal[i % 4], 2'(i % 4),
               1'b1, 1'b1, (i % 4) == 0);
    end

    // Scan with dwell 2: three cycles per channel, wrap every 12 cycles.
    for (int i = 0; i < 25; i++) begin
      applyStimulus(1'b1, 1'b1, 2'd0, 8'd2);
      checkAll($sformatf("scan2[%0d]", i), expVal[(i / 3) % 4],
               2'((i / 3) % 4), 1'b1, (i % 3) == 0, (i % 12) == 0);
    end

    // Back to manual, which clears the sweep.
    applyStimulus(1'b1, 1'b0, 2'd0, 8'd2);
    checkAll("manual0", 8'h11, 2'd0, 1'b1, 1'b1, 1'b0);

    // Dwell 5: channel 0 for 6 cycles, then channel 1 until its cnt reaches 4.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b1, 2'd0, 8'd5);
      checkAll($sformatf("scan5[%0d]", i), expVal[(i < 6) ? 0 : 1],
               (i < 6) ? 2'd0 : 2'd1, 1'b1, (i == 0) || (i == 6), i == 0);
    end

    // Lower the dwell below cnt: this cycle ends channel 1, and channel 2 follows.
    applyStimulus(1'b1, 1'b1, 2'd0, 8'd1);
    checkAll("dwlow.a", 8'h22, 2'd1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'd0, 8'd1);
    checkAll("dwlow.b", 8'h33, 2'd2, 1'b1, 1'b1, 1'b0);

    // Dwell 2 on channel 2, then freeze mid-dwell for 3 cycles.
    applyStimulus(1'b1, 1'b1, 2'd0, 8'd2);
    checkAll("prefrz", 8'h33, 2'd2, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 2'd0, 8'd2);
      checkAll($sformatf("freeze[%0d]", i), 8'h33, 2'd2, 1'b0, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 1'b1, 2'd0, 8'd2);
    checkAll("resume.a", 8'h33, 2'd2, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'd0, 8'd2);
    checkAll("resume.b", 8'h44, 2'd3, 1'b1, 1'b1, 1'b0);

    // Reset mid-scan, then the sweep restarts at channel 0.
    rst = 1'b1;
    applyStimulus(1'b1, 1'b1, 2'd0, 8'd2);
    checkAll("midrst", 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    applyStimulus(1'b1, 1'b1, 2'd0, 8'd2);
    checkAll("postrst.a", 8'h11, 2'd0, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 2'd0, 8'd2);
    checkAll("postrst.b", 8'h11, 2'd0, 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
